// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage data-memory controller with fixed access latency and pipeline stall.
// Optional misaligned-access detection and err_o port are enabled by DMEM_ALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        ack_o
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        err_o
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              wr_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [2**ADDR_W];

  logic req;
  logic fire;
  logic acc_ok;
  logic mem_we;
  logic unused_addr;

  assign req = MemRead_i | MemWrite_i;

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q;
  assign acc_ok      = !mis_q;
  assign unused_addr = ^addr_i[31:ADDR_W+2];
  assign err_o       = ack_o & mis_q;
`else
  assign acc_ok      = 1'b1;
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
`endif

  // The access commits on the last BUSY edge; a reset in that cycle discards it.
  assign fire   = (state_q == BUSY) && (cnt_q == 4'd0) && !rst_i;
  assign mem_we = fire && wr_q && acc_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= BUSY;
            cnt_q   <= 4'(LATENCY - 1);
            wr_q    <= MemWrite_i;
            idx_q   <= addr_i[ADDR_W+1:2];
            wdata_q <= wdata_i;
`ifdef DMEM_ALIGN_CHECK_EN
            mis_q   <= (addr_i[1:0] != 2'b00);
`endif
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= DONE;
            if (!wr_q) rdata_q <= acc_ok ? mem[idx_q] : 32'd0;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign rdata_o = rdata_q;
  assign ack_o   = (state_q == DONE) && !rst_i;
  assign stall_o = !rst_i && (((state_q == IDLE) && req) || (state_q == BUSY));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl (LATENCY 2 and LATENCY 1 instances).
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst  [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] ad   [2];
  logic [31:0] wdat [2];
  logic [31:0] rdo  [2];
  logic        st   [2];
  logic        ak   [2];
  logic        errw [2];

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(8), .LATENCY(2)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
    .addr_i(ad[0]), .wdata_i(wdat[0]), .rdata_o(rdo[0]), .stall_o(st[0]), .ack_o(ak[0])
`ifdef DMEM_ALIGN_CHECK_EN
    , .err_o(errw[0])
`endif
  );

  data_mem_ctrl #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
    .addr_i(ad[1]), .wdata_i(wdat[1]), .rdata_o(rdo[1]), .stall_o(st[1]), .ack_o(ak[1])
`ifdef DMEM_ALIGN_CHECK_EN
    , .err_o(errw[1])
`endif
  );

`ifndef DMEM_ALIGN_CHECK_EN
  assign errw[0] = 1'b0;
  assign errw[1] = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request stalls for LATENCY+1 cycles,
  // commits at the end of the last stalled cycle and acks in the following one.
  bit          m_act   [2];
  int          m_k     [2];
  bit          m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_data  [2];
  logic [31:0] m_rdata [2] = '{32'd0, 32'd0};
  logic [31:0] mm      [2][256];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int  lat;
      bit  es, ea, mis;
      lat = (d == 0) ? 2 : 1;
      es  = !rst[d] && (m_act[d] ? (m_k[d] <= lat) : (rd[d] || wr[d]));
      ea  = !rst[d] && m_act[d] && (m_k[d] == lat + 1);
      mis = (m_addr[d][1:0] != 2'b00);
      if (chk_en) begin
        chk($sformatf("stall%0d", d), {31'd0, st[d]}, {31'd0, es});
        chk($sformatf("ack%0d", d), {31'd0, ak[d]}, {31'd0, ea});
        chk($sformatf("rdata%0d", d), rdo[d], m_rdata[d]);
`ifdef DMEM_ALIGN_CHECK_EN
        chk($sformatf("err%0d", d), {31'd0, errw[d]}, {31'd0, ea && mis});
`endif
      end
      if (rst[d]) begin
        m_act[d]   = 1'b0;
        m_rdata[d] = 32'd0;
      end else if (m_act[d]) begin
        if (m_k[d] == lat) begin
`ifdef DMEM_ALIGN_CHECK_EN
          if (m_wr[d] && !mis) mm[d][m_addr[d][9:2]] = m_data[d];
          if (!m_wr[d]) m_rdata[d] = mis ? 32'd0 : mm[d][m_addr[d][9:2]];
`else
          if (m_wr[d]) mm[d][m_addr[d][9:2]] = m_data[d];
          else m_rdata[d] = mm[d][m_addr[d][9:2]];
`endif
        end
        if (m_k[d] == lat + 1) m_act[d] = 1'b0;
        else m_k[d]++;
      end else if (rd[d] || wr[d]) begin
        m_act[d]  = 1'b1;
        m_k[d]    = 1;
        m_wr[d]   = wr[d];
        m_addr[d] = ad[d];
        m_data[d] = wdat[d];
      end
    end
  end

  // Holds the request until the ack cycle, then drops it after that edge.
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] dat, output int nstall, output int ack_cyc,
                        output logic e);
    rd[d] = r; wr[d] = w; ad[d] = a; wdat[d] = dat;
    nstall = 0; ack_cyc = -1; e = 1'b0;
    for (int i = 0; i < 40 && ack_cyc < 0; i++) begin
      @(negedge clk);
      if (st[d]) nstall++;
      if (ak[d]) begin
        ack_cyc = i;
        e = errw[d];
      end
      @(posedge clk); #1;
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    if (ack_cyc < 0) begin
      checks++; errs++;
      $display("FAIL timeout: no ack on dut%0d for addr %h", d, a);
    end
  endtask

  int   ns, ac, nack;
  logic e;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = 32'd0; wdat[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", rdo[0], 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk_en = 1'b1;

    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ns, ac, e);
    chk("st_stall_cycles", ns, 3);
    chk("st_ack_cycle", ac, 3);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, ns, ac, e);
    chk("ld_stall_cycles", ns, 3);
    chk("ld_ack_cycle", ac, 3);
    chk("ld_data", rdo[0], 32'hDEADBEEF);

    access(0, 1'b0, 1'b1, 32'h400, 32'h11111111, ns, ac, e);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, ns, ac, e);
    chk("wrap_data", rdo[0], 32'h11111111);

    access(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, ns, ac, e);
    chk("rw_rdata_kept", rdo[0], 32'h11111111);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, ns, ac, e);
    chk("rw_readback", rdo[0], 32'hA5A5A5A5);

    access(0, 1'b0, 1'b1, 32'h30, 32'h0, ns, ac, e);
    wr[0] = 1'b1; ad[0] = 32'h30; wdat[0] = 32'h12345678;
    @(posedge clk); #1;
    rst[0] = 1'b1; wr[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("rst_stall_low", {31'd0, st[0]}, 32'd0);
    nack = ak[0] ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (ak[0]) nack++;
    end
    chk("rst_no_ack", nack, 0);
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, ns, ac, e);
    chk("rst_discarded", rdo[0], 32'h0);

    access(0, 1'b0, 1'b1, 32'h40, 32'h0, ns, ac, e);
    access(0, 1'b0, 1'b1, 32'h42, 32'hCAFEF00D, ns, ac, e);
    chk("mis_ack_cycle", ac, 3);
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, ns, ac, e);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_word_kept", rdo[0], 32'h0);
    access(0, 1'b1, 1'b0, 32'h42, 32'h0, ns, ac, e);
    chk("mis_read_err", {31'd0, e}, 32'd1);
    chk("mis_read_zero", rdo[0], 32'h0);
`else
    chk("mis_word_written", rdo[0], 32'hCAFEF00D);
`endif

    access(1, 1'b0, 1'b1, 32'h10, 32'h00000077, ns, ac, e);
    access(1, 1'b0, 1'b1, 32'h14, 32'h00000088, ns, ac, e);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, ns, ac, e);
    chk("l1_stall_cycles", ns, 2);
    chk("l1_ack_cycle", ac, 2);
    chk("l1_rd0", rdo[1], 32'h00000077);
    access(1, 1'b1, 1'b0, 32'h14, 32'h0, ns, ac, e);
    chk("l1_ack_cycle_b2b", ac, 2);
    chk("l1_rd1", rdo[1], 32'h00000088);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, ns, ac, e);
    chk("l1_rd2", rdo[1], 32'h00000077);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
